// File: rtl/count_pkg.sv
// Shared types and constants for the count event logger: the count type,
// the record layout and the wrap-detection helper.
package count_pkg;

    localparam int TS_WIDTH_DEF = 16;
    localparam int DEPTH_DEF    = 4;

    typedef logic [7:0] count_t;

    localparam count_t COUNT_MAX = 8'hFF;

    typedef struct packed {
        count_t                  count;
        logic [TS_WIDTH_DEF-1:0] ts;
        logic                    wrap;
    } count_event_t;

    // A wrap is only the single step from the top value back to zero.
    function automatic logic is_wrap(input count_t prev, input count_t cur);
        return (prev == COUNT_MAX) && (cur == count_t'(0));
    endfunction

endpackage

// File: rtl/count_event_logger_sync_fifo.sv
// First-word-fall-through FIFO with pointer-difference level. The head word is
// read straight from storage and is forced to zero while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign level_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push && !clear_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/count_event_logger.sv
// Watches the counter stage's count, timestamps each change and queues
// {count, ts, wrap} records for a valid/ready consumer; drops raise overflow.
module count_event_logger
    import count_pkg::*;
#(
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int TS_WIDTH = TS_WIDTH_DEF,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [7:0]          count_i,
    input  logic                clear_i,
    output logic                event_valid_o,
    input  logic                event_ready_i,
    output logic [7:0]          event_count_o,
    output logic [TS_WIDTH-1:0] event_ts_o,
    output logic                event_wrap_o,
    output logic                overflow_o,
    output logic [LW-1:0]       level_o
);

    localparam int REC_W = $bits(count_t) + TS_WIDTH + 1;

    count_t              prev_q, prev_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                overflow_q, overflow_d;
    logic                change;
    logic                wrap;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [REC_W-1:0]    rec_in;
    logic [REC_W-1:0]    rec_out;

    assign change = (count_i != prev_q);
    assign wrap   = is_wrap(prev_q, count_i);
    assign push   = change && !clear_i;
    assign pop    = event_valid_o && event_ready_i;
    assign rec_in = {count_i, ts_q, wrap};

    always_comb begin
        prev_d     = count_i;
        ts_d       = clear_i ? '0 : ts_q + 1'b1;
        overflow_d = overflow_q;
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prev_q     <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .clear_i  (clear_i),
        .push_i   (push),
        .pop_i    (pop),
        .data_i   (rec_in),
        .data_o   (rec_out),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level_o)
    );

    assign event_valid_o = !empty;
    assign overflow_o    = overflow_q;
    assign {event_count_o, event_ts_o, event_wrap_o} = rec_out;

endmodule

// File: tb/tb_count_event_logger.sv
// Directed scenarios plus random count/ready/clear traffic, every cycle
// compared against a queue-based model of the logger's behaviour.
module tb_count_event_logger;

    localparam int DEPTH = 4;
    localparam int TSW   = 16;

    logic           clock_i = 1'b0;
    logic           reset_ni = 1'b0;
    logic [7:0]     count_i = 8'h00;
    logic           clear_i = 1'b0;
    logic           event_ready_i = 1'b0;
    logic           event_valid_o;
    logic [7:0]     event_count_o;
    logic [TSW-1:0] event_ts_o;
    logic           event_wrap_o;
    logic           overflow_o;
    logic [2:0]     level_o;

    count_event_logger #(
        .DEPTH    (DEPTH),
        .TS_WIDTH (TSW)
    ) dut (
        .clock_i       (clock_i),
        .reset_ni      (reset_ni),
        .count_i       (count_i),
        .clear_i       (clear_i),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_count_o (event_count_o),
        .event_ts_o    (event_ts_o),
        .event_wrap_o  (event_wrap_o),
        .overflow_o    (overflow_o),
        .level_o       (level_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [7:0]     c;
        logic [TSW-1:0] ts;
        logic           w;
    } rec_t;

    rec_t           mq[$];
    logic [7:0]     m_prev;
    logic [TSW-1:0] m_ts;
    logic           m_ovf;
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(event_valid_o), 32'(mq.size() != 0));
        check("level", 32'(level_o), 32'(mq.size()));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        if (mq.size() != 0) begin
            check("head_count", 32'(event_count_o), 32'(mq[0].c));
            check("head_ts", 32'(event_ts_o), 32'(mq[0].ts));
            check("head_wrap", 32'(event_wrap_o), 32'(mq[0].w));
        end else begin
            check("idle_count", 32'(event_count_o), 32'h0);
            check("idle_ts", 32'(event_ts_o), 32'h0);
            check("idle_wrap", 32'(event_wrap_o), 32'h0);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = 8'h00;
        m_ts   = '0;
        m_ovf  = 1'b0;
    endtask

    // Applies one clock edge's worth of behaviour given the inputs held this cycle.
    task automatic model_update();
        int   n;
        bit   popped;
        rec_t r;
        if (clear_i) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ts   = '0;
            m_prev = count_i;
        end else begin
            n      = mq.size();
            popped = (n > 0) && event_ready_i;
            if (popped) begin
                r = mq.pop_front();
                $display("pop count=%02h ts=%0d wrap=%0b", r.c, r.ts, r.w);
            end
            if (count_i != m_prev) begin
                if (n < DEPTH || popped) begin
                    r.c  = count_i;
                    r.ts = m_ts;
                    r.w  = (m_prev == 8'hFF) && (count_i == 8'h00);
                    mq.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_ts   = m_ts + 1'b1;
            m_prev = count_i;
        end
    endtask

    task automatic step(input logic [7:0] c, input logic rdy, input logic clr);
        @(negedge clock_i);
        compare_all();
        count_i       = c;
        event_ready_i = rdy;
        clear_i       = clr;
        @(posedge clock_i);
        model_update();
    endtask

    initial begin
        logic [7:0] c;
        int         r;
        model_reset();
        repeat (2) @(posedge clock_i);
        #1;
        compare_all();
        @(negedge clock_i);
        #2 reset_ni = 1'b1;
        @(posedge clock_i);
        model_update();

        // Single steps with ready held high.
        step(8'h00, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);

        // Wrap from FF to 00.
        step(8'hFE, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Fill, then push while popping at full.
        for (int i = 0; i < 4; i++) step(8'h10 + 8'(i), 1'b0, 1'b0);
        step(8'h14, 1'b1, 1'b0);
        #1;
        check("full_push_pop_level", 32'(level_o), 32'd4);
        check("full_push_pop_ovf", 32'(overflow_o), 32'd0);

        // Drops while full.
        step(8'h15, 1'b0, 1'b0);
        step(8'h16, 1'b0, 1'b0);
        #1;
        check("drop_level", 32'(level_o), 32'd4);
        check("drop_ovf", 32'(overflow_o), 32'd1);

        // Pop one, then clear with three queued and a change in the clear cycle.
        step(8'h16, 1'b1, 1'b0);
        step(8'h20, 1'b0, 1'b1);
        #1;
        check("clear_valid", 32'(event_valid_o), 32'd0);
        check("clear_level", 32'(level_o), 32'd0);
        check("clear_ovf", 32'(overflow_o), 32'd0);
        step(8'h20, 1'b0, 1'b0);
        step(8'h21, 1'b0, 1'b0);
        step(8'h21, 1'b1, 1'b0);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 4; i++) step(8'h30 + 8'(i), 1'b0, 1'b0);
        step(8'h33, 1'b1, 1'b0);
        #2;
        reset_ni      = 1'b0;
        count_i       = 8'h00;
        event_ready_i = 1'b0;
        model_reset();
        #1;
        check("areset_valid", 32'(event_valid_o), 32'd0);
        check("areset_level", 32'(level_o), 32'd0);
        check("areset_ovf", 32'(overflow_o), 32'd0);
        @(negedge clock_i);
        #2 reset_ni = 1'b1;
        @(posedge clock_i);
        model_update();
        step(8'h00, 1'b1, 1'b0);
        step(8'h05, 1'b1, 1'b0);
        step(8'h05, 1'b1, 1'b0);
        step(8'h05, 1'b1, 1'b0);

        // Random traffic with periodic back-pressure windows.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      c = count_i;
            else if (r < 8) c = count_i + 8'd1;
            else if (r < 9) c = 8'($urandom_range(0, 255));
            else            c = 8'hFF;
            step(c,
                 ((i % 200) < 60) ? 1'b0 : 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) == 0));
        end
        @(negedge clock_i);
        compare_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
